// File: rtl/hex_scan_decoder_pkg.sv
// hex_pkg: segment table shared with the seven-segment encoder, plus the
// types and helpers used by the scan decoder.
//   SEG_0..SEG_F, SEG_BLANK : active-low patterns, bit0 = a .. bit6 = g
//   MAX_DIGITS              : upper bound on multiplexed digits
package hex_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'd64;
  localparam logic [6:0] SEG_1     = 7'd121;
  localparam logic [6:0] SEG_2     = 7'd36;
  localparam logic [6:0] SEG_3     = 7'd48;
  localparam logic [6:0] SEG_4     = 7'd25;
  localparam logic [6:0] SEG_5     = 7'd18;
  localparam logic [6:0] SEG_6     = 7'd2;
  localparam logic [6:0] SEG_7     = 7'd120;
  localparam logic [6:0] SEG_8     = 7'd0;
  localparam logic [6:0] SEG_9     = 7'd16;
  localparam logic [6:0] SEG_A     = 7'd8;
  localparam logic [6:0] SEG_B     = 7'd3;
  localparam logic [6:0] SEG_C     = 7'd39;
  localparam logic [6:0] SEG_D     = 7'd33;
  localparam logic [6:0] SEG_E     = 7'd6;
  localparam logic [6:0] SEG_F     = 7'd14;
  localparam logic [6:0] SEG_BLANK = 7'd127;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COUNT,
    ST_HOLD
  } scan_state_e;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] nibble;
  } seg_decode_t;

  // Exactly one bit set; zero and multi-hot both fail.
  function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/hex_scan_decoder_if.sv
// Bus between a multiplexed seven-segment source and the scan decoder.
//   master : drives seg_in / dig_sel, observes decoded results
//   slave  : the decoder (receives the bus, drives the results)
interface hex_scan_decoder_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic [2:0]              update_idx;
  logic                    err;
  logic [7:0]              err_count;

  modport master (
    output seg_in, dig_sel,
    input  value, digit_valid, update, update_idx, err, err_count
  );

  modport slave (
    input  seg_in, dig_sel,
    output value, digit_valid, update, update_idx, err, err_count
  );
endinterface

// File: rtl/hex_scan_decoder_seg_to_nibble.sv
// seg_to_nibble: combinational decode of an active-low 7-bit segment
// pattern against the shared table.
//   seg : pattern, bit0 = a .. bit6 = g
//   dec : {legal, blank, nibble}; blank and illegal both report legal = 0
module seg_to_nibble
  import hex_pkg::*;
(
  input  logic [6:0]  seg,
  output seg_decode_t dec
);

  always_comb begin
    dec.legal  = 1'b1;
    dec.blank  = 1'b0;
    dec.nibble = '0;
    case (seg)
      SEG_0: dec.nibble = 4'h0;
      SEG_1: dec.nibble = 4'h1;
      SEG_2: dec.nibble = 4'h2;
      SEG_3: dec.nibble = 4'h3;
      SEG_4: dec.nibble = 4'h4;
      SEG_5: dec.nibble = 4'h5;
      SEG_6: dec.nibble = 4'h6;
      SEG_7: dec.nibble = 4'h7;
      SEG_8: dec.nibble = 4'h8;
      SEG_9: dec.nibble = 4'h9;
      SEG_A: dec.nibble = 4'hA;
      SEG_B: dec.nibble = 4'hB;
      SEG_C: dec.nibble = 4'hC;
      SEG_D: dec.nibble = 4'hD;
      SEG_E: dec.nibble = 4'hE;
      SEG_F: dec.nibble = 4'hF;
      SEG_BLANK: begin
        dec.legal = 1'b0;
        dec.blank = 1'b1;
      end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/hex_scan_decoder.sv
// hex_scan_decoder: recovers per-digit nibbles from a multiplexed,
// active-low seven-segment bus with one-hot digit strobes.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of hex_scan_decoder_if
//     seg_in, dig_sel          : raw asynchronous display pins
//     value, digit_valid       : decoded digit register file
//     update, update_idx       : pulse + index per legal commit
//     err, err_count           : pulse per illegal commit, saturating count
module hex_scan_decoder
  import hex_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input logic               clk,
  input logic               rst_n,
  hex_scan_decoder_if.slave bus
);

  logic [6:0]              seg_s1, seg_s, seg_l;
  logic [NUM_DIGITS-1:0]   sel_s1, sel_s, sel_l;
  scan_state_e             state;
  logic [7:0]              count;
  logic [8:0]              cnt_inc;
  logic                    changed, commit, onehot;
  logic [2:0]              idx;
  seg_decode_t             dec;

  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    update_q, err_q;
  logic [2:0]              update_idx_q;
  logic [7:0]              err_count_q;

  seg_to_nibble u_dec (
    .seg (seg_s),
    .dec (dec)
  );

  always_comb begin
    changed = (seg_s != seg_l) || (sel_s != sel_l);
    cnt_inc = {1'b0, count} + 9'd1;
    onehot  = is_onehot(MAX_DIGITS'(sel_s));
    // A change of S restarts the count at 1, so only STABLE_CYCLES = 1
    // can commit on the very sample that differs; otherwise a change on
    // the would-be commit edge cancels it.
    if (changed)
      commit = (STABLE_CYCLES == 1);
    else
      commit = (state != ST_HOLD) && (cnt_inc >= 9'(STABLE_CYCLES));
    idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (sel_s[i]) idx = 3'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1       <= SEG_BLANK;
      seg_s        <= SEG_BLANK;
      seg_l        <= SEG_BLANK;
      sel_s1       <= '0;
      sel_s        <= '0;
      sel_l        <= '0;
      state        <= ST_WAIT;
      count        <= 8'd1;
      value_q      <= '0;
      valid_q      <= '0;
      update_q     <= 1'b0;
      update_idx_q <= '0;
      err_q        <= 1'b0;
      err_count_q  <= '0;
    end else begin
      seg_s1   <= bus.seg_in;
      sel_s1   <= bus.dig_sel;
      seg_s    <= seg_s1;
      sel_s    <= sel_s1;
      seg_l    <= seg_s;
      sel_l    <= sel_s;
      update_q <= 1'b0;
      err_q    <= 1'b0;

      if (changed) begin
        count <= 8'd1;
        state <= commit ? ST_HOLD : ST_WAIT;
      end else if (state != ST_HOLD) begin
        if (commit) begin
          state <= ST_HOLD;
        end else begin
          count <= cnt_inc[7:0];
          state <= ST_COUNT;
        end
      end

      if (commit && onehot) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel_s[i]) begin
            if (dec.legal) begin
              value_q[4*i +: 4] <= dec.nibble;
              valid_q[i]        <= 1'b1;
            end else begin
              valid_q[i] <= 1'b0;
            end
          end
        end
        if (dec.legal) begin
          update_q     <= 1'b1;
          update_idx_q <= idx;
        end else if (!dec.blank) begin
          err_q <= 1'b1;
          if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = update_idx_q;
  assign bus.err         = err_q;
  assign bus.err_count   = err_count_q;

endmodule

// File: tb/tb_hex_scan_decoder.sv
module tb_hex_scan_decoder;

  localparam int LAT = 5; // 2 + STABLE_CYCLES edges, counted from the drive negedge

  typedef struct {
    bit         is_err;
    int         idx;
    logic [3:0] nib;
    int         ecnt;
    int         cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_err = 0;
  exp_t sb[$];

  hex_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  hex_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // kind: 0 = no pulse expected, 1 = update, 2 = err
  task automatic apply(input logic [6:0] s, input logic [3:0] sel, input int hold,
                       input int kind, input int idx, input logic [3:0] nib);
    exp_t e;
    bus.seg_in  = s;
    bus.dig_sel = sel;
    if (kind == 1) begin
      e = '{is_err: 1'b0, idx: idx, nib: nib, ecnt: 0, cyc: cyc + LAT};
      sb.push_back(e);
    end else if (kind == 2) begin
      if (exp_err < 255) exp_err++;
      e = '{is_err: 1'b1, idx: idx, nib: 4'h0, ecnt: exp_err, cyc: cyc + LAT};
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.update || bus.err)) begin
        vectors++;
        if (bus.update && bus.err) begin
          miscompares++;
          $display("FAIL pulse_overlap: update and err both high at cycle %0d", cyc);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: update=%0b err=%0b idx=%0d at cycle %0d, none expected",
                   bus.update, bus.err, bus.update_idx, cyc);
        end else begin
          e = sb.pop_front();
          if (e.is_err)
            ok = bus.err && (cyc == e.cyc) && (int'(bus.err_count) == e.ecnt)
                 && (bus.digit_valid[e.idx] == 1'b0);
          else
            ok = bus.update && (cyc == e.cyc) && (int'(bus.update_idx) == e.idx)
                 && (bus.value[4*e.idx +: 4] == e.nib) && bus.digit_valid[e.idx];
          if (!ok) begin
            miscompares++;
            $display("FAIL commit: got err=%0b upd=%0b idx=%0d nib=%0h errcnt=%0d valid=%0b cyc=%0d; expected err=%0b idx=%0d nib=%0h errcnt=%0d cyc=%0d",
                     bus.err, bus.update, bus.update_idx, bus.value[4*e.idx +: 4], bus.err_count,
                     bus.digit_valid, cyc, e.is_err, e.idx, e.nib, e.ecnt, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int c;
    exp_t e;
    rst_n       = 1'b0;
    bus.seg_in  = 7'd127;
    bus.dig_sel = 4'b0000;
    repeat (2) @(negedge clk);
    chk("reset_value", 32'(bus.value), 32'h0);
    chk("reset_valid", 32'(bus.digit_valid), 32'h0);
    chk("reset_update", 32'(bus.update), 32'h0);
    chk("reset_idx", 32'(bus.update_idx), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    chk("reset_errcnt", 32'(bus.err_count), 32'h0);
    rst_n = 1'b1;

    // Single stable digit
    apply(7'd36, 4'b0001, 8, 1, 0, 4'h2);
    chk("first_nibble", 32'(bus.value[3:0]), 32'h2);
    chk("first_valid", 32'(bus.digit_valid), 32'h1);

    // Scan four digits: F, A, 8, 1
    apply(7'd14,  4'b0001, 6, 1, 0, 4'hF);
    apply(7'd8,   4'b0010, 6, 1, 1, 4'hA);
    apply(7'd0,   4'b0100, 6, 1, 2, 4'h8);
    apply(7'd121, 4'b1000, 6, 1, 3, 4'h1);
    chk("scan_value", 32'(bus.value), 32'h18AF);
    chk("scan_valid", 32'(bus.digit_valid), 32'hF);

    // Glitch: 64 -> 0 (a legal '8') for 2 cycles, back to 64
    apply(7'd64, 4'b0010, 6, 1, 1, 4'h0);
    apply(7'd0,  4'b0010, 2, 0, 1, 4'h0);
    apply(7'd64, 4'b0010, 6, 1, 1, 4'h0);
    chk("glitch_value", 32'(bus.value), 32'h180F);

    // Illegal after legal 9 on digit 2
    apply(7'd16,  4'b0100, 6, 1, 2, 4'h9);
    apply(7'd126, 4'b0100, 6, 2, 2, 4'h0);
    chk("illegal_keep_nibble", 32'(bus.value[11:8]), 32'h9);
    chk("illegal_valid", 32'(bus.digit_valid), 32'hB);
    chk("illegal_errcnt", 32'(bus.err_count), 32'd1);
    for (int i = 0; i < 300; i++)
      apply((i % 2 == 0) ? 7'd125 : 7'd126, 4'b0100, 4, 2, 2, 4'h0);
    repeat (4) @(negedge clk);
    chk("errcnt_saturated", 32'(bus.err_count), 32'd255);

    // Blank on digit 3, then multi-hot select
    apply(7'd127, 4'b1000, 6, 0, 3, 4'h0);
    chk("blank_valid", 32'(bus.digit_valid), 32'h3);
    apply(7'd36, 4'b0110, 6, 0, 1, 4'h0);
    chk("multihot_valid", 32'(bus.digit_valid), 32'h3);
    chk("multihot_value", 32'(bus.value), 32'h190F);
    chk("errcnt_held", 32'(bus.err_count), 32'd255);

    // Async reset mid-count
    apply(7'd48, 4'b0001, 2, 0, 0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_value", 32'(bus.value), 32'h0);
    chk("async_valid", 32'(bus.digit_valid), 32'h0);
    chk("async_idx", 32'(bus.update_idx), 32'h0);
    chk("async_errcnt", 32'(bus.err_count), 32'h0);
    exp_err = 0;
    repeat (2) @(negedge clk);
    bus.seg_in  = 7'd121;
    bus.dig_sel = 4'b0001;
    c = cyc;
    e = '{is_err: 1'b0, idx: 0, nib: 4'h1, ecnt: 0, cyc: c + LAT};
    sb.push_back(e);
    #3 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_reset_value", 32'(bus.value), 32'h1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: no %s for digit %0d, expected at cycle %0d",
               e.is_err ? "err" : "update", e.idx, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
